watch_set_controller: RTL and testbench

WATCH_SET_CONTROLLER -- requirements
Module: watch_set_controller

---
 rtl/watch_set_controller.sv | 122 ++++++++++++
 tb/tb_watch_set_controller.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/watch_set_controller.sv
// rtl/watch_set_controller.sv - time-of-day counter with button-driven hour/min/sec setting
// Buttons are edge-detected against their previous level; btn_mode cycles RUN->SET_HOUR->SET_MIN->SET_SEC.
module watch_set_controller #(
   parameter int HOUR_INIT = 12,
   parameter int MIN_INIT  = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_tick,
   input  logic       btn_mode,
   input  logic       btn_up,
   input  logic       btn_down,
   output logic [6:0] msec,
   output logic [5:0] sec,
   output logic [5:0] min,
   output logic [4:0] hour,
   output logic [2:0] pos_sel
);

   localparam logic [1:0] RUN      = 2'd0;
   localparam logic [1:0] SET_HOUR = 2'd1;
   localparam logic [1:0] SET_MIN  = 2'd2;
   localparam logic [1:0] SET_SEC  = 2'd3;

   logic [1:0] state, state_nxt;
   logic       mode_q, up_q, down_q;
   logic       mode_ev, up_ev, down_ev, adjust;
   logic [6:0] msec_nxt;
   logic [5:0] sec_nxt, min_nxt;
   logic [4:0] hour_nxt;
   logic [2:0] pos_sel_nxt;

   assign mode_ev = btn_mode & ~mode_q;
   assign up_ev   = btn_up   & ~up_q;
   assign down_ev = btn_down & ~down_q;
   // A simultaneous mode press or an up+down pair suppresses the field edit.
   assign adjust  = ~mode_ev & (up_ev ^ down_ev);

   always_comb begin
      state_nxt = state;
      msec_nxt  = msec;
      sec_nxt   = sec;
      min_nxt   = min;
      hour_nxt  = hour;

      if (mode_ev) begin
         unique case (state)
            RUN:      state_nxt = SET_HOUR;
            SET_HOUR: state_nxt = SET_MIN;
            SET_MIN:  state_nxt = SET_SEC;
            default: begin
               state_nxt = RUN;
               msec_nxt  = 7'd0;
            end
         endcase
      end

      if (state == RUN) begin
         if (i_tick) begin
            if (msec == 7'd99) begin
               msec_nxt = 7'd0;
               if (sec == 6'd59) begin
                  sec_nxt = 6'd0;
                  if (min == 6'd59) begin
                     min_nxt  = 6'd0;
                     hour_nxt = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
                  end else begin
                     min_nxt = min + 6'd1;
                  end
               end else begin
                  sec_nxt = sec + 6'd1;
               end
            end else begin
               msec_nxt = msec + 7'd1;
            end
         end
      end else if (adjust) begin
         unique case (state)
            SET_HOUR: hour_nxt = up_ev ? ((hour == 5'd23) ? 5'd0 : hour + 5'd1)
                                       : ((hour == 5'd0) ? 5'd23 : hour - 5'd1);
            SET_MIN:  min_nxt  = up_ev ? ((min == 6'd59) ? 6'd0 : min + 6'd1)
                                       : ((min == 6'd0) ? 6'd59 : min - 6'd1);
            default:  sec_nxt  = up_ev ? ((sec == 6'd59) ? 6'd0 : sec + 6'd1)
                                       : ((sec == 6'd0) ? 6'd59 : sec - 6'd1);
         endcase
      end
   end

   always_comb begin
      unique case (state_nxt)
         SET_HOUR: pos_sel_nxt = 3'b100;
         SET_MIN:  pos_sel_nxt = 3'b010;
         SET_SEC:  pos_sel_nxt = 3'b001;
         default:  pos_sel_nxt = 3'b000;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= RUN;
         pos_sel <= 3'b000;
         msec    <= 7'd0;
         sec     <= 6'd0;
         min     <= 6'(MIN_INIT);
         hour    <= 5'(HOUR_INIT);
         mode_q  <= 1'b0;
         up_q    <= 1'b0;
         down_q  <= 1'b0;
      end else begin
         state   <= state_nxt;
         pos_sel <= pos_sel_nxt;
         msec    <= msec_nxt;
         sec     <= sec_nxt;
         min     <= min_nxt;
         hour    <= hour_nxt;
         mode_q  <= btn_mode;
         up_q    <= btn_up;
         down_q  <= btn_down;
      end
   end

endmodule

// File: tb/tb_watch_set_controller.sv
// tb/tb_watch_set_controller.sv - randomized scoreboard bench for watch_set_controller
// Reference model keeps time as centiseconds since midnight and derives fields arithmetically.
module tb_watch_set_controller;

   localparam int HOUR_INIT = 12;
   localparam int MIN_INIT  = 0;
   localparam int DAY_CS    = 24 * 60 * 60 * 100;

   logic       clk = 1'b0;
   logic       rst, i_tick, btn_mode, btn_up, btn_down;
   logic [6:0] msec;
   logic [5:0] sec, min;
   logic [4:0] hour;
   logic [2:0] pos_sel;

   watch_set_controller #(.HOUR_INIT(HOUR_INIT), .MIN_INIT(MIN_INIT)) dut (
      .clk(clk), .rst(rst), .i_tick(i_tick), .btn_mode(btn_mode), .btn_up(btn_up),
      .btn_down(btn_down), .msec(msec), .sec(sec), .min(min), .hour(hour), .pos_sel(pos_sel)
   );

   always #5 clk = ~clk;

   int          t_cs;
   int          mode_idx;
   bit          pm, pu, pd;
   logic [2:0]  psel_tab [4] = '{3'b000, 3'b100, 3'b010, 3'b001};
   logic [26:0] sb [$];
   int          vectors = 0;
   int          miscompares = 0;

   task automatic model_reset();
      t_cs = (HOUR_INIT * 60 + MIN_INIT) * 6000;
      mode_idx = 0;
      pm = 0; pu = 0; pd = 0;
   endtask

   task automatic model_edge(input bit m, input bit u, input bit d, input bit tk);
      bit em, eu, ed;
      int h, mi, s, cs, delta;
      em = m & !pm; eu = u & !pu; ed = d & !pd;
      h = t_cs / 360000; mi = (t_cs / 6000) % 60; s = (t_cs / 100) % 60; cs = t_cs % 100;
      if (mode_idx == 0) begin
         if (tk) t_cs = (t_cs + 1) % DAY_CS;
      end else if (!em && (eu != ed)) begin
         delta = eu ? 1 : -1;
         case (mode_idx)
            1: h  = (h + delta + 24) % 24;
            2: mi = (mi + delta + 60) % 60;
            default: s = (s + delta + 60) % 60;
         endcase
         t_cs = ((h * 60 + mi) * 60 + s) * 100 + cs;
      end
      if (em) begin
         if (mode_idx == 3) t_cs = t_cs - (t_cs % 100);
         mode_idx = (mode_idx + 1) % 4;
      end
      pm = m; pu = u; pd = d;
   endtask

   task automatic push_expected();
      sb.push_back({7'(t_cs % 100), 6'((t_cs / 100) % 60), 6'((t_cs / 6000) % 60),
                    5'(t_cs / 360000), psel_tab[mode_idx]});
   endtask

   task automatic step(input bit r, input bit m, input bit u, input bit d, input bit tk);
      @(negedge clk);
      rst = r; btn_mode = m; btn_up = u; btn_down = d; i_tick = tk;
      if (!r) model_reset();
      else model_edge(m, u, d, tk);
      push_expected();
   endtask

   task automatic press(input bit m, input bit u, input bit d);
      step(1, m, u, d, 0);
      step(1, 0, 0, 0, 0);
   endtask

   // Reset lands between edges: one expectation for the reset edge itself, one for the next clock.
   task automatic async_reset();
      @(negedge clk);
      #2;
      model_reset();
      push_expected();
      push_expected();
      rst = 1'b0;
   endtask

   initial begin
      logic [26:0] exp_v, act_v;
      @(negedge clk);
      forever begin
         @(posedge clk or negedge rst);
         #1;
         act_v = {msec, sec, min, hour, pos_sel};
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL vec %0d no_expectation got %0d:%0d:%0d.%0d pos_sel=%b",
                     vectors, hour, min, sec, msec, pos_sel);
         end else begin
            exp_v = sb.pop_front();
            if (act_v !== exp_v) begin
               miscompares++;
               $display("FAIL vec %0d fields got %0d:%0d:%0d.%0d pos_sel=%b exp %0d:%0d:%0d.%0d pos_sel=%b",
                        vectors, hour, min, sec, msec, pos_sel,
                        exp_v[7:3], exp_v[13:8], exp_v[19:14], exp_v[26:20], exp_v[2:0]);
            end
         end
      end
   end

   initial begin
      rst = 1'b0; i_tick = 1'b0; btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
      model_reset();
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);

      repeat (100) step(1, 0, 0, 0, 1);

      press(1, 0, 0);
      repeat (13) press(0, 0, 1);
      repeat (3) press(1, 0, 0);

      press(1, 0, 0);
      press(1, 0, 0);
      press(0, 0, 1);
      press(1, 0, 0);
      press(0, 0, 1);
      press(0, 0, 1);
      press(1, 0, 0);
      repeat (99) step(1, 0, 0, 0, 1);
      step(1, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0);

      press(1, 0, 0);
      press(1, 0, 0);
      repeat (50) step(1, 0, 1, 0, 1'($urandom_range(0, 1)));
      step(1, 0, 0, 0, 1);

      repeat (3) press(1, 0, 0);
      press(1, 1, 0);
      press(0, 1, 1);
      press(0, 1, 0);

      press(1, 0, 0);
      async_reset();
      step(0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);

      press(1, 0, 0);
      async_reset();
      step(0, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0);

      repeat (3000) begin
         if ($urandom_range(0, 199) == 0) begin
            async_reset();
            step(0, 0, 0, 0, 0);
         end else begin
            step(1, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0);
         end
      end

      @(negedge clk);
      #2;
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL vec %0d drain got %0d pending exp 0", vectors, sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
